// File: rtl/cnn_bias_act_requant_pkg.sv
// cnn_bias_act_requant_pkg: shared activation encodings and default widths
package cnn_bias_act_requant_pkg;
  typedef enum logic {ACT_LINEAR = 1'b0, ACT_RELU = 1'b1} act_mode_e;
  localparam int DEF_OUT_CH  = 3;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_BIAS_W  = 16;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_CNT_W   = 16;
endpackage

// File: rtl/cnn_bias_act_requant_lane.sv
// requant_lane: per-channel round-half-up shift, optional ReLU and clip with sat flag
module requant_lane #(
  parameter int ACC_W   = 24,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
) (
  input  logic signed [ACC_W:0]   sum,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    relu,
  output logic [OUT_W-1:0]        feat,
  output logic                    sat
);
  localparam int RW = ACC_W + 2;
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  logic signed [RW-1:0] rnd, r, a;
  always_comb begin
    rnd  = (shift == '0) ? '0 : RW'(1) << (shift - 1'b1);
    r    = (RW'(sum) + rnd) >>> shift;
    a    = (relu && r < 0) ? '0 : r;
    sat  = (a > MAXV) || (a < MINV);
    feat = (a > MAXV) ? MAXV[OUT_W-1:0] : (a < MINV) ? MINV[OUT_W-1:0] : a[OUT_W-1:0];
  end
endmodule

// File: rtl/cnn_bias_act_requant.sv
// cnn_bias_act_requant: two-stage bias add / requant pipeline with valid-ready and saturation counter
module cnn_bias_act_requant
  import cnn_bias_act_requant_pkg::*;
#(
  parameter int OUT_CH  = DEF_OUT_CH,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int BIAS_W  = DEF_BIAS_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [OUT_CH*ACC_W-1:0]   s_acc,
  input  logic [OUT_CH*BIAS_W-1:0]  biases,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      act_mode,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_CH*OUT_W-1:0]   m_feat,
  output logic [CNT_W-1:0]          sat_count,
  input  logic                      clr_sat
);
  localparam int SW = ACC_W + 1;
  logic                    s1_valid_q, s1_valid_d, s1_relu_q, s1_relu_d;
  logic [OUT_CH*SW-1:0]    s1_sum_q, s1_sum_d, bias_sum;
  logic [SHIFT_W-1:0]      s1_shift_q, s1_shift_d;
  logic                    m_valid_q, m_valid_d;
  logic [OUT_CH*OUT_W-1:0] m_feat_q, m_feat_d, lane_feat;
  logic [OUT_CH-1:0]       lane_sat;
  logic [CNT_W-1:0]        sat_count_q, sat_count_d;
  logic [CNT_W:0]          sat_inc, sat_sum;
  logic                    s2_load, s_fire, s2_take;
  assign s2_load = !m_valid_q || m_ready;
  assign s_ready = !s1_valid_q || s2_load;
  assign s_fire  = s_valid && s_ready;
  assign s2_take = s2_load && s1_valid_q;
  genvar g;
  for (g = 0; g < OUT_CH; g++) begin : g_lane
    requant_lane #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)) u_lane (
      .sum  (s1_sum_q[g*SW +: SW]),
      .shift(s1_shift_q),
      .relu (s1_relu_q),
      .feat (lane_feat[g*OUT_W +: OUT_W]),
      .sat  (lane_sat[g])
    );
  end
  always_comb begin
    bias_sum = '0;
    sat_inc  = '0;
    for (int c = 0; c < OUT_CH; c++) begin
      bias_sum[c*SW +: SW] = SW'($signed(s_acc[c*ACC_W +: ACC_W])) + SW'($signed(biases[c*BIAS_W +: BIAS_W]));
      sat_inc = sat_inc + (CNT_W+1)'(lane_sat[c] && s2_take);
    end
    s1_valid_d  = s_fire || (s1_valid_q && !s2_load);
    s1_sum_d    = s_fire ? bias_sum : s1_sum_q;
    s1_shift_d  = s_fire ? shift : s1_shift_q;
    s1_relu_d   = s_fire ? (act_mode == ACT_RELU) : s1_relu_q;
    m_valid_d   = s2_load ? s1_valid_q : m_valid_q;
    m_feat_d    = s2_take ? lane_feat : m_feat_q;
    sat_sum     = {1'b0, sat_count_q} + sat_inc;
    sat_count_d = clr_sat ? '0 : sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_feat_q    <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      m_valid_q   <= m_valid_d;
      m_feat_q    <= m_feat_d;
      sat_count_q <= sat_count_d;
    end
  end
  assign m_valid   = m_valid_q;
  assign m_feat    = m_feat_q;
  assign sat_count = sat_count_q;
endmodule

// File: tb/tb_cnn_bias_act_requant.sv
// tb_cnn_bias_act_requant: directed table-driven bench for the bias/act/requant stage
module tb_cnn_bias_act_requant;
  localparam int OUT_CH = 2, ACC_W = 20, BIAS_W = 16, OUT_W = 8, SHIFT_W = 5, CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk, reset_n, s_valid, s_ready, act_mode, m_valid, m_ready, clr_sat;
  logic [OUT_CH*ACC_W-1:0]  s_acc;
  logic [OUT_CH*BIAS_W-1:0] biases;
  logic [SHIFT_W-1:0]       shift;
  logic [OUT_CH*OUT_W-1:0]  m_feat;
  logic [CNT_W-1:0]         sat_count;
  typedef struct {
    logic signed [ACC_W-1:0]  acc0, acc1;
    logic signed [BIAS_W-1:0] b0, b1;
    logic [SHIFT_W-1:0]       sh;
    logic                     mode;
    logic signed [OUT_W-1:0]  e0, e1;
    int                       dsat;
  } vec_t;
  vec_t tbl[12];
  vec_t strm[4];
  int checks = 0, errors = 0, exp_cnt = 0;
  cnn_bias_act_requant #(.OUT_CH(OUT_CH), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W),
                         .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_acc(s_acc),
    .biases(biases), .shift(shift), .act_mode(act_mode), .m_valid(m_valid), .m_ready(m_ready),
    .m_feat(m_feat), .sat_count(sat_count), .clr_sat(clr_sat)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic vec_t mk(int a0, int a1, int b0, int b1, int sh, int md, int e0, int e1, int ds);
    vec_t v;
    v.acc0 = ACC_W'(a0);
    v.acc1 = ACC_W'(a1);
    v.b0 = BIAS_W'(b0);
    v.b1 = BIAS_W'(b1);
    v.sh = SHIFT_W'(sh);
    v.mode = md[0];
    v.e0 = OUT_W'(e0);
    v.e1 = OUT_W'(e1);
    v.dsat = ds;
    return v;
  endfunction
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(vec_t v);
    s_acc = {v.acc1, v.acc0};
    biases = {v.b1, v.b0};
    shift = v.sh;
    act_mode = v.mode;
  endtask
  task automatic chk_feat(string name, vec_t v);
    chk({name, "_ch0"}, $signed(m_feat[OUT_W-1:0]), v.e0);
    chk({name, "_ch1"}, $signed(m_feat[2*OUT_W-1:OUT_W]), v.e1);
  endtask
  task automatic run_stream(int n, int stall);
    int idx = 0, oidx = 0, cyc = 0, first = -1, last = -1;
    while (oidx < n && cyc < 40) begin
      tick();
      if (idx < n) drive(strm[idx]);
      s_valid = (idx < n);
      m_ready = (cyc >= stall);
      #1;
      if (stall > 0 && cyc == stall - 1) begin
        chk("bp_accepted", idx, 2);
        chk("bp_s_ready_low", s_ready, 0);
      end
      if (m_valid && !m_ready) chk_feat("stall_hold", strm[0]);
      if (m_valid && m_ready) begin
        chk_feat("stream_out", strm[oidx]);
        if (first < 0) first = cyc;
        last = cyc;
        oidx++;
      end
      if (s_valid && s_ready) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("stream_count", oidx, n);
    chk("stream_nogap", last - first, n - 1);
  endtask
  initial begin
    tbl[0]  = mk(100, -50, -20, 10, 2, 1, 20, 0, 0);
    tbl[1]  = mk(6, -6, 0, 0, 2, 0, 2, -1, 0);
    tbl[2]  = mk(-50, 0, 10, 0, 0, 0, -40, 0, 0);
    tbl[3]  = mk(5000, -5000, 0, 0, 2, 0, 127, -128, 2);
    tbl[4]  = mk(5000, -5000, 0, 0, 2, 1, 127, 0, 1);
    tbl[5]  = mk(5, -5, 0, 0, 1, 0, 3, -2, 0);
    tbl[6]  = mk(127, -128, 0, 0, 0, 0, 127, -128, 0);
    tbl[7]  = mk(128, -129, 0, 0, 0, 0, 127, -128, 2);
    tbl[8]  = mk(-524288, 524287, -32768, 32767, 16, 0, -8, 8, 0);
    tbl[9]  = mk(300, -1, 0, 0, 0, 1, 127, 0, 1);
    tbl[10] = mk(5000, -5000, 0, 0, 2, 0, 127, -128, 2);
    tbl[11] = mk(200, -200, 0, 0, 0, 0, 127, -128, 2);
    reset_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; clr_sat = 1'b0;
    s_acc = '0; biases = '0; shift = '0; act_mode = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_feat", m_feat, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_s_ready", s_ready, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      drive(tbl[i]);
      s_valid = 1'b1;
      #1;
      chk("tbl_s_ready", s_ready, 1);
      tick();
      s_valid = 1'b0;
      #1;
      chk("tbl_lat1_m_valid", m_valid, 0);
      tick();
      #1;
      chk("tbl_lat2_m_valid", m_valid, 1);
      chk_feat("tbl", tbl[i]);
      exp_cnt = (exp_cnt + tbl[i].dsat > CNT_MAX) ? CNT_MAX : exp_cnt + tbl[i].dsat;
      chk("tbl_sat_count", sat_count, exp_cnt);
    end
    tick();
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    #1;
    chk("clr_sat", sat_count, 0);
    tick();
    drive(tbl[3]);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    #1;
    chk("clr_prio_m_valid", m_valid, 1);
    chk("clr_prio_sat", sat_count, 0);
    for (int i = 0; i < 4; i++) strm[i] = mk(11 * (i + 1), -3 * (i + 1), 0, 0, 0, 0, 11 * (i + 1), -3 * (i + 1), 0);
    run_stream(4, 6);
    strm[0] = mk(-40, 40, 0, 0, 0, 0, -40, 40, 0);
    strm[1] = mk(-40, 40, 0, 0, 3, 1, 0, 5, 0);
    strm[2] = mk(-40, 40, 0, 0, 3, 0, -5, 5, 0);
    strm[3] = mk(-40, 40, 0, 0, 0, 1, 0, 40, 0);
    run_stream(4, 0);
    tick();
    chk("pre_mid_sat", sat_count, 0);
    m_ready = 1'b0;
    drive(tbl[3]);
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    #1;
    chk("mid_full_s_ready", s_ready, 0);
    chk("mid_sat_count", sat_count, 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_feat", m_feat, 0);
    chk("mid_rst_sat", sat_count, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("no_stale_beat", m_valid, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
